// File: rtl/cnn_layer_accel_pkg.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_pkg
// Shared types and constants for the CNN layer accelerator quad.
//   job_ctrl_state_t : job control handshake FSM states
//   JOB_PARAM_W      : width of the job descriptor
//   JOB_CNT_W        : width of the result beat count (descriptor low bits)
//   job_param_t      : descriptor layout, {cfg, result_count}
// -----------------------------------------------------------------------------
package cnn_layer_accel_pkg;

  localparam int JOB_PARAM_W = 128;
  localparam int JOB_CNT_W   = 32;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_REQ  = 3'd1,
    FETCH_WAIT = 3'd2,
    RUN        = 3'd3,
    COMPLETE   = 3'd4
  } job_ctrl_state_t;

  typedef struct packed {
    logic [JOB_PARAM_W-JOB_CNT_W-1:0] cfg;
    logic [JOB_CNT_W-1:0]             result_count;
  } job_param_t;

endpackage

// File: rtl/cnn_layer_accel_job_ctrl.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_job_ctrl
// Quad-side responder for the host job control handshake. Accepts a job,
// latches its descriptor, runs the fetch request/ack/complete exchange,
// launches the datapath and counts result beats, then holds job_complete
// until the host acknowledges.
//
// Ports (all outputs registered, clk_if rising edge, rst async active-low):
//   job_start          in   host requests a job (held until job_accept)
//   job_accept         out  1-cycle pulse, descriptor latched
//   job_parameters     in   descriptor {cfg, result_count}
//   job_fetch_request  out  level, asks host to fetch job data
//   job_fetch_ack      in   host acknowledges the fetch request
//   job_fetch_complete in   1-cycle pulse, job data delivered
//   job_complete       out  level, held until job_complete_ack
//   job_complete_ack   in   host acknowledges completion
//   run_start          out  1-cycle pulse on RUN entry
//   run_params         out  latched cfg field, stable between accepts
//   result_beat        in   one per datapath result beat
//   busy               out  high in every state except IDLE
// -----------------------------------------------------------------------------
module cnn_layer_accel_job_ctrl
  import cnn_layer_accel_pkg::*;
#(
  parameter int PARAM_W = JOB_PARAM_W,
  parameter int CNT_W   = JOB_CNT_W
) (
  input  logic                     clk_if,
  input  logic                     rst,
  input  logic                     job_start,
  output logic                     job_accept,
  input  logic [PARAM_W-1:0]       job_parameters,
  output logic                     job_fetch_request,
  input  logic                     job_fetch_ack,
  input  logic                     job_fetch_complete,
  output logic                     job_complete,
  input  logic                     job_complete_ack,
  output logic                     run_start,
  output logic [PARAM_W-CNT_W-1:0] run_params,
  input  logic                     result_beat,
  output logic                     busy
);

  job_ctrl_state_t          state_q;
  logic                     job_accept_q;
  logic                     job_fetch_request_q;
  logic                     job_complete_q;
  logic                     run_start_q;
  logic                     busy_q;
  logic [PARAM_W-CNT_W-1:0] run_params_q;
  logic [CNT_W-1:0]         count_q;
  logic [CNT_W-1:0]         beat_cnt_q;
  logic                     last_beat;

  // Only meaningful when count_q != 0; the zero-count case is handled
  // separately so the N-1 underflow never matters.
  assign last_beat = (beat_cnt_q == (count_q - CNT_W'(1)));

  always_ff @(posedge clk_if or negedge rst) begin
    if (!rst) begin
      state_q             <= IDLE;
      job_accept_q        <= 1'b0;
      job_fetch_request_q <= 1'b0;
      job_complete_q      <= 1'b0;
      run_start_q         <= 1'b0;
      busy_q              <= 1'b0;
      run_params_q        <= '0;
      count_q             <= '0;
      beat_cnt_q          <= '0;
    end else begin
      // Pulse outputs default low every cycle.
      job_accept_q <= 1'b0;
      run_start_q  <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (job_start) begin
            job_accept_q        <= 1'b1;
            run_params_q        <= job_parameters[PARAM_W-1:CNT_W];
            count_q             <= job_parameters[CNT_W-1:0];
            job_fetch_request_q <= 1'b1;
            busy_q              <= 1'b1;
            state_q             <= FETCH_REQ;
          end
        end

        FETCH_REQ: begin
          if (job_fetch_ack) begin
            job_fetch_request_q <= 1'b0;
            // Data may already be complete in the ack cycle: skip the wait.
            if (job_fetch_complete) begin
              run_start_q <= 1'b1;
              beat_cnt_q  <= '0;
              state_q     <= RUN;
            end else begin
              state_q <= FETCH_WAIT;
            end
          end
        end

        FETCH_WAIT: begin
          if (job_fetch_complete) begin
            run_start_q <= 1'b1;
            beat_cnt_q  <= '0;
            state_q     <= RUN;
          end
        end

        RUN: begin
          if (count_q == '0) begin
            job_complete_q <= 1'b1;
            state_q        <= COMPLETE;
          end else if (result_beat) begin
            if (last_beat) begin
              job_complete_q <= 1'b1;
              state_q        <= COMPLETE;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end

        COMPLETE: begin
          if (job_complete_ack) begin
            job_complete_q <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign job_accept        = job_accept_q;
  assign job_fetch_request = job_fetch_request_q;
  assign job_complete      = job_complete_q;
  assign run_start         = run_start_q;
  assign run_params        = run_params_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// Self-checking bench for cnn_layer_accel_job_ctrl. The host side is driven
// at the transaction level; expected outputs follow from the handshake rules
// (a job of N beats completes on the cycle after its Nth counted beat).
module tb_cnn_layer_accel_job_ctrl;
  import cnn_layer_accel_pkg::*;

  logic         clk_if = 1'b0;
  logic         rst;
  logic         job_start;
  logic         job_accept;
  logic [127:0] job_parameters;
  logic         job_fetch_request;
  logic         job_fetch_ack;
  logic         job_fetch_complete;
  logic         job_complete;
  logic         job_complete_ack;
  logic         run_start;
  logic [95:0]  run_params;
  logic         result_beat;
  logic         busy;

  int checks = 0;
  int errors = 0;

  cnn_layer_accel_job_ctrl #(.PARAM_W(128), .CNT_W(32)) dut (
    .clk_if             (clk_if),
    .rst                (rst),
    .job_start          (job_start),
    .job_accept         (job_accept),
    .job_parameters     (job_parameters),
    .job_fetch_request  (job_fetch_request),
    .job_fetch_ack      (job_fetch_ack),
    .job_fetch_complete (job_fetch_complete),
    .job_complete       (job_complete),
    .job_complete_ack   (job_complete_ack),
    .run_start          (run_start),
    .run_params         (run_params),
    .result_beat        (result_beat),
    .busy               (busy)
  );

  always #5 clk_if = ~clk_if;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_if);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_accept"}, {127'd0, job_accept}, 128'd0);
    check({tag, "_freq"},   {127'd0, job_fetch_request}, 128'd0);
    check({tag, "_cmpl"},   {127'd0, job_complete}, 128'd0);
    check({tag, "_rstart"}, {127'd0, run_start}, 128'd0);
    check({tag, "_busy"},   {127'd0, busy}, 128'd0);
    check({tag, "_params"}, {32'd0, run_params}, 128'd0);
  endtask

  // One complete job. Entered in IDLE (1 time unit after an edge), leaves in
  // IDLE. If b2b is set, the next job's start is raised while in COMPLETE.
  task automatic run_job(input logic [95:0] cfg, input logic [31:0] n, input bit simul,
                         input int ack_dly, input int wait_dly, input bit spurious,
                         input bit b2b, input logic [127:0] next_par);
    job_param_t p;
    int left;
    int gap;
    int hold;
    p.cfg          = cfg;
    p.result_count = n;

    // Accept
    job_start      = 1'b1;
    job_parameters = p;
    tick();
    check("accept", {127'd0, job_accept}, 128'd1);
    check("busy_acc", {127'd0, busy}, 128'd1);
    check("freq_acc", {127'd0, job_fetch_request}, 128'd1);
    check("params_acc", {32'd0, run_params}, {32'd0, cfg});
    job_start      = spurious;
    job_parameters = {$urandom, $urandom, $urandom, $urandom};

    // Fetch request held until ack
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      check("accept_once", {127'd0, job_accept}, 128'd0);
      check("freq_hold", {127'd0, job_fetch_request}, 128'd1);
    end
    job_fetch_ack      = 1'b1;
    job_fetch_complete = simul;
    tick();
    job_fetch_ack      = 1'b0;
    job_fetch_complete = 1'b0;
    check("accept_once2", {127'd0, job_accept}, 128'd0);
    check("freq_drop", {127'd0, job_fetch_request}, 128'd0);
    if (simul) begin
      check("rstart_simul", {127'd0, run_start}, 128'd1);
    end else begin
      check("rstart_nofc", {127'd0, run_start}, 128'd0);
      for (int i = 0; i < wait_dly; i++) begin
        result_beat   = spurious;
        job_fetch_ack = spurious;
        tick();
        check("rstart_wait", {127'd0, run_start}, 128'd0);
        check("cmpl_wait", {127'd0, job_complete}, 128'd0);
        check("freq_wait", {127'd0, job_fetch_request}, 128'd0);
      end
      result_beat        = 1'b0;
      job_fetch_ack      = 1'b0;
      job_fetch_complete = 1'b1;
      tick();
      job_fetch_complete = 1'b0;
      check("rstart", {127'd0, run_start}, 128'd1);
    end

    // Run: job completes on the cycle after its Nth beat
    left = int'(n);
    if (n == 0) begin
      job_start = 1'b0;
      tick();
      check("cmpl_zero", {127'd0, job_complete}, 128'd1);
      check("rstart_pulse0", {127'd0, run_start}, 128'd0);
    end else begin
      while (left > 0) begin
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          job_start          = spurious;
          job_complete_ack   = spurious;
          job_fetch_complete = spurious;
          tick();
          check("cmpl_gap", {127'd0, job_complete}, 128'd0);
          check("rstart_gap", {127'd0, run_start}, 128'd0);
          check("busy_run", {127'd0, busy}, 128'd1);
          check("accept_run", {127'd0, job_accept}, 128'd0);
        end
        job_start          = 1'b0;
        job_complete_ack   = 1'b0;
        job_fetch_complete = 1'b0;
        result_beat        = 1'b1;
        tick();
        result_beat = 1'b0;
        left--;
        check("cmpl_beat", {127'd0, job_complete}, {127'd0, left == 0});
        check("rstart_beat", {127'd0, run_start}, 128'd0);
      end
    end

    // Complete held until ack
    job_start = 1'b0;
    if (b2b) begin
      job_start      = 1'b1;
      job_parameters = next_par;
    end
    hold = int'($urandom_range(0, 3));
    for (int i = 0; i < hold; i++) begin
      result_beat = spurious;
      tick();
      check("cmpl_hold", {127'd0, job_complete}, 128'd1);
      check("busy_hold", {127'd0, busy}, 128'd1);
      check("accept_cmpl", {127'd0, job_accept}, 128'd0);
      check("params_hold", {32'd0, run_params}, {32'd0, cfg});
    end
    result_beat      = 1'b0;
    job_complete_ack = 1'b1;
    tick();
    job_complete_ack = 1'b0;
    check("cmpl_drop", {127'd0, job_complete}, 128'd0);
    check("busy_idle", {127'd0, busy}, 128'd0);
    check("accept_idle", {127'd0, job_accept}, 128'd0);
    check("params_idle", {32'd0, run_params}, {32'd0, cfg});
    $display("job cfg=%h n=%0d simul=%0b spur=%0b b2b=%0b done", cfg, n, simul, spurious, b2b);
  endtask

  localparam int NRAND = 20;
  logic [95:0] rcfg [NRAND];
  logic [31:0] rcnt [NRAND];
  bit          rb2b [NRAND];

  initial begin
    job_param_t np;
    rst = 1'b0;
    job_start = 1'b0;
    job_parameters = '0;
    job_fetch_ack = 1'b0;
    job_fetch_complete = 1'b0;
    job_complete_ack = 1'b0;
    result_beat = 1'b0;

    #2;
    check_all_zero("reset");
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Directed scenarios
    run_job(96'hA5, 32'd4, 1'b0, 2, 1, 1'b0, 1'b0, '0);                 // nominal
    run_job(96'h1234, 32'd0, 1'b0, 0, 0, 1'b0, 1'b0, '0);               // zero count
    run_job(96'hBEEF, 32'd3, 1'b1, 1, 0, 1'b0, 1'b0, '0);               // ack+complete together
    run_job(96'hC0DE, 32'd4, 1'b0, 1, 3, 1'b1, 1'b0, '0);               // spurious inputs
    np.cfg = 96'h5151; np.result_count = 32'd2;
    run_job(96'h7777, 32'd1, 1'b0, 0, 0, 1'b0, 1'b1, np);               // back-to-back
    run_job(96'h5151, 32'd2, 1'b1, 0, 0, 1'b0, 1'b0, '0);

    // Reset mid-RUN after 2 of 4 beats
    np.cfg = 96'hDEAD; np.result_count = 32'd4;
    job_start = 1'b1;
    job_parameters = np;
    tick();
    job_start = 1'b0;
    job_fetch_ack = 1'b1;
    job_fetch_complete = 1'b1;
    tick();
    job_fetch_ack = 1'b0;
    job_fetch_complete = 1'b0;
    result_beat = 1'b1;
    tick();
    tick();
    result_beat = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    tick();
    check_all_zero("midrun_reset_hold");
    rst = 1'b1;
    tick();
    check_all_zero("after_midrun");
    run_job(96'hF00D, 32'd1, 1'b0, 1, 1, 1'b0, 1'b0, '0);

    // Randomized jobs
    for (int i = 0; i < NRAND; i++) begin
      rcfg[i] = {$urandom, $urandom, $urandom};
      rcnt[i] = 32'($urandom_range(0, 6));
      rb2b[i] = (i != NRAND - 1) && ($urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < NRAND; i++) begin
      if (i != NRAND - 1) begin
        np.cfg = rcfg[i+1];
        np.result_count = rcnt[i+1];
      end else begin
        np = '0;
      end
      run_job(rcfg[i], rcnt[i], ($urandom_range(0, 1) == 1),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 1) == 1), rb2b[i], np);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_layer_accel_job_ctrl.md
Name: cnn_layer_accel_job_ctrl

Overview:
Quad-side responder for the job control handshake driven by the host/testbench on the quad interface. It accepts job_start and latches job_parameters. It then runs the fetch request/ack/complete exchange, launches the datapath, and counts result beats. Finally it raises job_complete until acknowledged. It sits in the clk_if domain at the top of cnn_layer_accel_quad, ahead of the config/pixel/weight datapaths.

Parameters:
PARAM_W, 128, width of job_parameters
CNT_W, 32, width of result beat count field (job_parameters[CNT_W-1:0])

Ports:
clk_if  input  1  sole clock; all logic rising-edge
rst  input  1  asynchronous, active-low reset
job_start  input  1  host requests job; held high until job_accept seen
job_accept  output  1  one-cycle pulse: job taken, parameters latched
job_parameters  input  PARAM_W  job descriptor; valid while job_start high
job_fetch_request  output  1  level; requests host fetch of job data
job_fetch_ack  input  1  host acknowledges fetch request
job_fetch_complete  input  1  one-cycle pulse: host finished delivering job data
job_complete  output  1  level; job finished, held until ack
job_complete_ack  input  1  host acknowledges completion
run_start  output  1  one-cycle pulse to datapath on RUN entry
run_params  output  PARAM_W-CNT_W  latched job_parameters[PARAM_W-1:CNT_W], stable from accept to next accept
result_beat  input  1  datapath result_valid & result_accept, one per beat
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst low, async): state=IDLE. job_accept, job_fetch_request, job_complete, run_start, busy=0. run_params=0, beat counter=0, latched count=0.
- All outputs are registered. No combinational path from input to output.
- States: IDLE, FETCH_REQ, FETCH_WAIT, RUN, COMPLETE.
- IDLE:
  - job_start sampled high at edge -> next cycle: job_accept=1 (exactly one cycle), latch job_parameters, state=FETCH_REQ, job_fetch_request=1, busy=1.
  - job_start low -> stay.
- FETCH_REQ: job_fetch_request held high.
  - job_fetch_ack high and job_fetch_complete high in the same cycle -> drop request, go to RUN.
  - job_fetch_ack high only -> drop request next cycle, go to FETCH_WAIT.
- FETCH_WAIT: job_fetch_complete high -> go to RUN.
- RUN entry: run_start=1 for one cycle and beat counter cleared to 0.
  - Latched count N==0 -> go straight to COMPLETE on the cycle after run_start; no beats counted.
  - Otherwise each result_beat increments the counter. The beat with counter==N-1 moves to COMPLETE next cycle; job_complete=1 that cycle.
- COMPLETE: job_complete held high until job_complete_ack sampled high.
  - The next cycle: job_complete=0, busy=0, state=IDLE.
  - A new job_start sampled in that same IDLE cycle is accepted normally. There is no back-to-back accept from COMPLETE.
- Ignored inputs (no effect):
  - job_start outside IDLE, including the cycle after accept while the host is still holding it.
  - job_fetch_ack outside FETCH_REQ.
  - job_fetch_complete in IDLE, RUN or COMPLETE.
  - result_beat outside RUN.
  - job_complete_ack outside COMPLETE.
- Counter is CNT_W bits and never wraps: N max = 2^CNT_W-1, so the terminal compare occurs first.
- Mid-operation reset: all state abandoned immediately and outputs forced to reset values; no completion is issued.

Decomposition:
- Package cnn_layer_accel_pkg: job_ctrl_state_t enum (IDLE, FETCH_REQ, FETCH_WAIT, RUN, COMPLETE); JOB_PARAM_W=128 and JOB_CNT_W=32 constants; a job_param_t packed struct splitting {cfg, result_count}.
- Sub-module: none. FSM plus counter fits one module of about 150-200 lines.

Test Plan:
- Nominal job: job_parameters count=4, cfg=96'hA5. Start -> job_accept pulse 1 cycle after start; job_fetch_request high until ack; fetch_complete -> run_start pulse; 4 result_beat -> job_complete; ack -> busy=0, run_params=96'hA5.
- Zero count: count=0 -> run_start, then job_complete the following cycle with no beats required.
- Simultaneous ack+complete: job_fetch_ack and job_fetch_complete both high in FETCH_REQ -> RUN directly, FETCH_WAIT never entered, run_start next cycle.
- Spurious inputs: result_beat x3 during FETCH_WAIT, job_start held through RUN, job_complete_ack in RUN -> no extra accept, counter still needs 4 beats in RUN, job_complete unaffected.
- Back-to-back jobs: second job_start asserted while first is in COMPLETE -> accepted only after ack returns FSM to IDLE; run_params updates to second cfg on second accept.
- Reset mid-RUN after 2 of 4 beats: rst low 1 cycle -> all outputs 0 asynchronously, state IDLE; new job with count=1 then completes after exactly 1 beat.
